// File: rtl/seq_tb_pkg.sv
// Shared types and constants for the sequential-cell stimulus/check blocks.
// Holds the checker FSM encoding, the LFSR polynomial and the default seed.
package seq_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Taps x^8+x^6+x^5+x^4+1: feedback = b7^b5^b4^b3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_SEED  = 8'hA5;
  localparam int         LAT_MAX   = 3;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dff_stim_checker_if.sv
// Stimulus/response bundle between the checker and whoever drives start and q_in.
// master = checker side, slave = environment/DUT side.
interface dff_stim_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             q_in;
  logic             d_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;

  modport master (
    input  start, q_in,
    output d_out, busy, done, pass, err_cnt, vec_cnt
  );

  modport slave (
    output start, q_in,
    input  d_out, busy, done, pass, err_cnt, vec_cnt
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable; reset loads the seed.
// A zero seed is replaced by 8'h01 so the register never locks up.
module lfsr8
  import seq_tb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_seed,
  output logic       o_bit
);

  logic [7:0] r_lfsr;
  logic [7:0] w_seed;

  assign w_seed = (i_seed == 8'h00) ? 8'h01 : i_seed;

  always_ff @(posedge clk) begin
    if (!rst_n || i_load) begin
      r_lfsr <= w_seed;
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/dff_stim_checker.sv
// Drives an LFSR bit stream into a storage-cell DUT and compares its q against the
// stream delayed by LAT clocks; reports saturating mismatch count and pass/fail.
module dff_stim_checker
  import seq_tb_pkg::*;
#(
  parameter int         N_VEC = 16,
  parameter int         LAT   = 1,
  parameter logic [7:0] SEED  = DEF_SEED,
  parameter int         CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dff_stim_checker_if.master  bus
);

  if (N_VEC < 1 || N_VEC > 255 || N_VEC > (2 ** CNT_W) - 1) begin : g_bad_nvec
    $error("dff_stim_checker: N_VEC out of range or does not fit CNT_W");
  end
  if (LAT < 0 || LAT > LAT_MAX) begin : g_bad_lat
    $error("dff_stim_checker: LAT out of range");
  end

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(N_VEC - 1);
  localparam logic [1:0]       LAT_CNT  = 2'(LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_run;
  logic             w_chk;
  logic             w_cmp_err;
  logic             w_lfsr_bit;
  logic             r_d_out;
  logic [LAT:0]     r_exp;
  logic [LAT:0]     r_vld;
  logic [1:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_vec_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_vec_cnt == LAST_VEC) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == LAT_CNT) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_run = (r_state == ST_RUN);
  assign w_chk = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  // e[0] tracks d_out, so a LAT-deep DUT's q lines up with e[LAT].
  assign w_cmp_err = w_chk && r_vld[LAT] && (bus.q_in != r_exp[LAT]);

  lfsr8 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_en   (w_run),
    .i_seed (SEED),
    .o_bit  (w_lfsr_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_out     <= 1'b0;
      r_exp       <= '0;
      r_vld       <= '0;
      r_drain_cnt <= '0;
      r_err_cnt   <= '0;
      r_vec_cnt   <= '0;
    end else if (w_load) begin
      r_exp       <= '0;
      r_vld       <= '0;
      r_drain_cnt <= '0;
      r_err_cnt   <= '0;
      r_vec_cnt   <= '0;
    end else begin
      if (w_chk) begin
        if (w_run) r_exp[0] <= w_lfsr_bit;
        r_vld[0] <= w_run;
        for (int i = 1; i <= LAT; i++) begin
          r_exp[i] <= r_exp[i-1];
          r_vld[i] <= r_vld[i-1];
        end
      end
      if (w_run) begin
        r_d_out   <= w_lfsr_bit;
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      end
      if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= '0;
      end
      if (w_cmp_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.d_out   = r_d_out;
  assign bus.busy    = w_chk;
  assign bus.done    = (r_state == ST_DONE);
  assign bus.pass    = (r_state == ST_DONE) && (r_err_cnt == '0);
  assign bus.err_cnt = r_err_cnt;
  assign bus.vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_dff_stim_checker.sv
// Bench for dff_stim_checker: flop/inverting/stuck-at DUTs on a LAT=1 instance,
// a transparent latch on a LAT=0 instance, plus reset and held-start scenarios.
module tb_dff_stim_checker;

  localparam int N   = 16;
  localparam int LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_stim_checker_if #(.CNT_W(8)) bus1 ();
  dff_stim_checker_if #(.CNT_W(8)) bus0 ();

  dff_stim_checker #(.N_VEC(N), .LAT(LAT), .SEED(8'hA5), .CNT_W(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  dff_stim_checker #(.N_VEC(N), .LAT(0), .SEED(8'hA5), .CNT_W(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;   // 0 flop, 1 inverted flop, 2 stuck-at-0
  logic dut_q  = 1'b0;
  logic q_lat  = 1'b0;

  always @(posedge clk) dut_q <= bus1.d_out;
  always_latch if (clk) q_lat <= bus0.d_out;

  assign bus1.q_in = (mode == 0) ? dut_q : (mode == 1) ? ~dut_q : 1'b0;
  assign bus0.q_in = q_lat;

  // Reference stream and run timeline for the LAT=1 instance
  bit          m_bits [N];
  int          m_ones;
  logic [15:0] m_word;
  int          m_cyc      = -1;  // clocks since the accepting edge, -1 = no run
  int          m_exp_err  = 0;
  int          m_next_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_model();
    int s;
    int fb;
    s      = 8'hA5;
    m_ones = 0;
    m_word = '0;
    for (int i = 0; i < N; i++) begin
      m_bits[i] = bit'(s % 2);
      m_word[i] = m_bits[i];
      m_ones   += s % 2;
      fb = ((s / 128) + (s / 32) + (s / 16) + (s / 8)) % 2;
      s  = ((s * 2) % 256) + fb;
    end
  endtask

  // Per-cycle check of the LAT=1 instance against the run timeline
  initial begin
    forever begin
      @(negedge clk);
      if (m_cyc >= 0) begin
        if (m_cyc < N) begin
          chk("run_busy", bus1.busy, 1);
          chk("run_done", bus1.done, 0);
          chk("run_vec", bus1.vec_cnt, m_cyc);
          if (m_cyc >= 1) chk("run_dout", bus1.d_out, m_bits[m_cyc-1]);
          else            chk("run_err0", bus1.err_cnt, 0);
        end else if (m_cyc <= N + LAT) begin
          chk("drain_busy", bus1.busy, 1);
          chk("drain_done", bus1.done, 0);
          chk("drain_vec", bus1.vec_cnt, N);
          chk("drain_dout", bus1.d_out, m_bits[N-1]);
        end else begin
          chk("done_busy", bus1.busy, 0);
          chk("done_done", bus1.done, 1);
          chk("done_vec", bus1.vec_cnt, N);
          chk("done_err", bus1.err_cnt, m_exp_err);
          chk("done_pass", bus1.pass, (m_exp_err == 0) ? 1 : 0);
        end
      end
      if (rst_n && bus1.start && (m_cyc < 0 || m_cyc > N + LAT)) begin
        m_cyc     = 0;
        m_exp_err = m_next_err;
      end else if (m_cyc >= 0) begin
        m_cyc++;
      end
    end
  end

  task automatic start1(input int exp_err);
    m_next_err = exp_err;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
  endtask

  task automatic wait1();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (bus1.done === 1'b1) break;
    end
    chk("done1_in_time", (k < 200) ? 1 : 0, 1);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bcnt;
    build_model();
    chk("model_stream", m_word, 16'h6EE5);
    chk("model_ones", m_ones, 10);

    // Reset with start asserted: nothing may begin
    bus1.start = 1'b1;
    bus0.start = 1'b1;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus1.busy, 0);
    chk("rst_done", bus1.done, 0);
    chk("rst_pass", bus1.pass, 0);
    chk("rst_err", bus1.err_cnt, 0);
    chk("rst_vec", bus1.vec_cnt, 0);
    chk("rst_dout", bus1.d_out, 0);
    chk("rst_busy0", bus0.busy, 0);
    rst_n      = 1'b1;
    bus1.start = 1'b0;
    bus0.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", bus1.busy, 0);
    chk("idle_done", bus1.done, 0);

    // Ideal flop, inverting flop, stuck-at-0
    mode = 0; start1(0);      wait1();
    mode = 1; start1(N);      wait1();
    mode = 2; start1(m_ones); wait1();

    // One-clock reset at vec_cnt==7, then a clean run
    mode = 0; start1(0);
    for (k = 0; k < 50; k++) begin
      if (bus1.vec_cnt == 8'd7) break;
      @(posedge clk); #1;
    end
    chk("vec7_reached", (k < 50) ? 1 : 0, 1);
    rst_n = 1'b0;
    m_cyc = -1;
    @(posedge clk); #1;
    chk("abort_busy", bus1.busy, 0);
    chk("abort_done", bus1.done, 0);
    chk("abort_vec", bus1.vec_cnt, 0);
    chk("abort_dout", bus1.d_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_done", bus1.done, 0);
    start1(0); wait1();

    // start held through the run and into DONE: restart only from DONE
    mode       = 1;
    m_next_err = N;
    bus1.start = 1'b1;
    wait1();
    mode       = 0;
    m_next_err = 0;
    @(posedge clk); #1;
    chk("restart_busy", bus1.busy, 1);
    chk("restart_done", bus1.done, 0);
    chk("restart_err", bus1.err_cnt, 0);
    bus1.start = 1'b0;
    wait1();

    // Transparent latch on the LAT=0 instance
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bcnt = 0;
    for (k = 0; k < 100; k++) begin
      if (bus0.busy !== 1'b1) break;
      bcnt++;
      @(posedge clk); #1;
    end
    chk("latch_busy_cycles", bcnt, N + 1);
    chk("latch_done", bus0.done, 1);
    chk("latch_err", bus0.err_cnt, 0);
    chk("latch_pass", bus0.pass, 1);
    chk("latch_vec", bus0.vec_cnt, N);
    chk("latch_dout", bus0.d_out, m_bits[N-1]);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
